// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-address sequencer for the soft-CPU instruction path.
// Holds the fetch PC, issues in-order imem requests under valid/ready,
// tracks in-flight requests in an {epoch, addr} tag FIFO and tags each
// returned word with its address, dropping words made stale by a redirect.
module pc_sequencer #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MAX_OUT    = 4,
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic                         clk_main_a0,
   input  logic                         rst_main_n,
   input  logic                         start,
   input  logic [31:0]                  start_addr,
   input  logic                         halt,
   input  logic                         redirect_valid,
   input  logic [31:0]                  redirect_addr,
   output logic [31:0]                  inc_in_address,
   input  logic [31:0]                  inc_out_address,
   output logic                         imem_req_valid,
   input  logic                         imem_req_ready,
   output logic [31:0]                  imem_req_addr,
   input  logic                         imem_rsp_valid,
   input  logic [DATA_W-1:0]            imem_rsp_data,
   output logic                         inst_valid,
   output logic [31:0]                  inst_addr,
   output logic [DATA_W-1:0]            inst_data,
   output logic [$clog2(MAX_OUT):0]     outstanding,
   output logic                         busy,
   output logic                         err
);

   localparam int unsigned PTR_W = $clog2(MAX_OUT);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [31:0]        r_pc, w_pc_nxt;
   logic               r_epoch, w_epoch_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
   logic               r_tag_ep   [MAX_OUT];
   logic [31:0]        r_tag_addr [MAX_OUT];

   logic               r_inst_valid;
   logic [31:0]        r_inst_addr;
   logic [DATA_W-1:0]  r_inst_data;
   logic               r_err;

   logic               w_req_valid;
   logic               w_accept;
   logic               w_fifo_empty;
   logic               w_pop;
   logic               w_hit;

   // Handshake qualifiers: valid never looks at ready; a response only pops a non-empty FIFO.
   always_comb begin
      w_fifo_empty = (r_cnt == '0);
      w_req_valid  = (r_state == FETCH) && (r_cnt < MAX_CNT) && !redirect_valid && !halt;
      w_accept     = w_req_valid && imem_req_ready;
      w_pop        = imem_rsp_valid && !w_fifo_empty;
      w_hit        = w_pop && (r_tag_ep[r_rd_ptr] == r_epoch);
      w_cnt_nxt    = r_cnt;
      if (w_accept && !w_pop)
         w_cnt_nxt = r_cnt + CNT_W'(1);
      else if (!w_accept && w_pop)
         w_cnt_nxt = r_cnt - CNT_W'(1);
   end

   // Next-state, next-PC and epoch decode; halt outranks redirect in FETCH.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_epoch_nxt = r_epoch;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_pc_nxt    = start_addr;
               w_state_nxt = FETCH;
            end
         end
         FETCH: begin
            if (halt) begin
               w_state_nxt = DRAIN;
            end else if (redirect_valid) begin
               w_pc_nxt    = redirect_addr;
               w_epoch_nxt = ~r_epoch;
            end else if (w_accept) begin
               w_pc_nxt    = inc_out_address;
            end
         end
         DRAIN: begin
            if (w_cnt_nxt == '0)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Control registers: state, PC, epoch and in-flight count.
   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         r_state <= IDLE;
         r_pc    <= RESET_ADDR;
         r_epoch <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_epoch <= w_epoch_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Tag FIFO pointers; depth is a power of two so they wrap naturally.
   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_accept)
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
   end

   // Tag FIFO storage; contents are only meaningful behind the pointers.
   always_ff @(posedge clk_main_a0) begin
      if (w_accept) begin
         r_tag_ep[r_wr_ptr]   <= r_epoch;
         r_tag_addr[r_wr_ptr] <= r_pc;
      end
   end

   // Tagged instruction output and sticky underflow error.
   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         r_inst_valid <= 1'b0;
         r_inst_addr  <= '0;
         r_inst_data  <= '0;
         r_err        <= 1'b0;
      end else begin
         r_inst_valid <= w_hit;
         if (w_hit) begin
            r_inst_addr <= r_tag_addr[r_rd_ptr];
            r_inst_data <= imem_rsp_data;
         end
         if (imem_rsp_valid && w_fifo_empty)
            r_err <= 1'b1;
      end
   end

   assign inc_in_address = r_pc;
   assign imem_req_addr  = r_pc;
   assign imem_req_valid = w_req_valid;
   assign inst_valid     = r_inst_valid;
   assign inst_addr      = r_inst_addr;
   assign inst_data      = r_inst_data;
   assign outstanding    = r_cnt;
   assign busy           = (r_state != IDLE) || (r_cnt != '0);
   assign err            = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: randomized bench for pc_sequencer against a queue-based
// reference model of the fetch sequencer and a latency-modelled memory.
module tb_pc_sequencer;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned MAX_OUT = 4;
   localparam int unsigned CNT_W   = $clog2(MAX_OUT) + 1;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [31:0]        start_addr;
   logic               halt;
   logic               redirect_valid;
   logic [31:0]        redirect_addr;
   logic [31:0]        inc_in_address;
   logic [31:0]        inc_out_address;
   logic               imem_req_valid;
   logic               imem_req_ready;
   logic [31:0]        imem_req_addr;
   logic               imem_rsp_valid;
   logic [DATA_W-1:0]  imem_rsp_data;
   logic               inst_valid;
   logic [31:0]        inst_addr;
   logic [DATA_W-1:0]  inst_data;
   logic [CNT_W-1:0]   outstanding;
   logic               busy;
   logic               err;

   pc_sequencer #(
      .DATA_W     (DATA_W),
      .MAX_OUT    (MAX_OUT),
      .RESET_ADDR (32'h0000_0000)
   ) dut (
      .clk_main_a0     (clk),
      .rst_main_n      (rst_n),
      .start           (start),
      .start_addr      (start_addr),
      .halt            (halt),
      .redirect_valid  (redirect_valid),
      .redirect_addr   (redirect_addr),
      .inc_in_address  (inc_in_address),
      .inc_out_address (inc_out_address),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .inst_valid      (inst_valid),
      .inst_addr       (inst_addr),
      .inst_data       (inst_data),
      .outstanding     (outstanding),
      .busy            (busy),
      .err             (err)
   );

   // External incrementor
   assign inc_out_address = inc_in_address + 32'd1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
   endtask

   // Reference model: mode 0=idle, 1=fetching, 2=draining
   typedef struct {
      logic        ep;
      logic [31:0] a;
   } tag_t;
   typedef struct {
      logic [31:0] a;
      int unsigned due;
   } pend_t;

   int unsigned   m_mode;
   logic [31:0]   m_pc;
   logic          m_epoch;
   tag_t          m_q[$];
   logic          m_err;
   logic          m_iv;
   logic [31:0]   m_ia;
   logic [31:0]   m_id;
   pend_t         pend[$];
   int unsigned   cyc;
   int unsigned   lat_lo, lat_hi;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_pc = 32'h0; m_epoch = 1'b0; m_q.delete();
      m_err = 1'b0; m_iv = 1'b0; m_ia = 32'h0; m_id = 32'h0;
      pend.delete();
   endtask

   task automatic check_reset_values();
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_req_addr",  imem_req_addr, 0);
      check("rst_inst_valid", inst_valid, 0);
      check("rst_inst_addr", inst_addr, 0);
      check("rst_inst_data", inst_data, 0);
      check("rst_outstanding", outstanding, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
   endtask

   // Compare DUT against the model, then advance the model by one clock.
   task automatic model_cycle();
      logic  exp_v;
      logic  acc;
      logic  nv;
      tag_t  t;
      pend_t p;
      exp_v = (m_mode == 1) && (m_q.size() < MAX_OUT) && !redirect_valid && !halt;
      check("req_valid", imem_req_valid, exp_v);
      check("req_addr", imem_req_addr, m_pc);
      check("inc_in", inc_in_address, m_pc);
      check("outstanding", outstanding, m_q.size());
      check("busy", busy, (m_mode != 0) || (m_q.size() != 0));
      check("err", err, m_err);
      check("inst_valid", inst_valid, m_iv);
      check("inst_addr", inst_addr, m_ia);
      check("inst_data", inst_data, m_id);
      acc = exp_v && imem_req_ready;
      nv  = 1'b0;
      if (imem_rsp_valid) begin
         if (m_q.size() == 0) begin
            m_err = 1'b1;
         end else begin
            t = m_q.pop_front();
            if (t.ep == m_epoch) begin
               nv = 1'b1; m_ia = t.a; m_id = imem_rsp_data;
            end
         end
      end
      m_iv = nv;
      case (m_mode)
         0: if (start) begin m_pc = start_addr; m_mode = 1; end
         1: begin
            if (halt) m_mode = 2;
            else if (redirect_valid) begin m_pc = redirect_addr; m_epoch = ~m_epoch; end
            else if (acc) begin
               t.ep = m_epoch; t.a = m_pc; m_q.push_back(t);
               p.a = m_pc; p.due = cyc + $urandom_range(lat_hi, lat_lo); pend.push_back(p);
               m_pc = m_pc + 32'd1;
            end
         end
         default: if (m_q.size() == 0) m_mode = 0;
      endcase
   endtask

   // Memory returns accepted requests in order once their latency expires.
   task automatic mem_drive();
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(pend[0].a);
         void'(pend.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
      cyc++;
      mem_drive();
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; start_addr = '0; halt = 1'b0;
      redirect_valid = 1'b0; redirect_addr = '0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      cyc = 0; lat_lo = 2; lat_hi = 2;
      model_reset();
      #2;
      check_reset_values();
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem_drive();

      // Streaming from 0x100, latency 2: never more than 2 in flight
      start = 1'b1; start_addr = 32'h100; imem_req_ready = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         check("out_le2", outstanding <= 2, 1);
         step();
      end
      // Back-pressure for 5 cycles, then resume with longer latency
      imem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) step();
      imem_req_ready = 1'b1; lat_lo = 4; lat_hi = 4;
      for (int i = 0; i < 6; i++) step();
      redirect_valid = 1'b1; redirect_addr = 32'h400;
      step();
      redirect_valid = 1'b0;
      for (int i = 0; i < 12; i++) step();

      // Randomized traffic
      lat_lo = 1; lat_hi = 7;
      for (int i = 0; i < 3000; i++) begin
         start          = (m_mode == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
         start_addr     = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFE : $urandom;
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
         halt           = ($urandom_range(0, 39) == 0);
         imem_req_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      // Halt and drain to idle within a bounded number of cycles
      start = 1'b0; redirect_valid = 1'b0; halt = 1'b1; imem_req_ready = 1'b1;
      step();
      halt = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (m_mode == 0 && pend.size() == 0) break;
         step();
      end
      step();
      check("drained_busy", busy, 0);

      // Response with nothing outstanding sets sticky err
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
      step();
      for (int i = 0; i < 3; i++) step();
      check("err_sticky", err, 1);

      // Reset in the middle of fetching clears everything at once
      start = 1'b1; start_addr = 32'h0000_2000;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      #2 rst_n = 1'b0;
      #1;
      check_reset_values();
      model_reset();
      imem_rsp_valid = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-address sequencer for the soft-CPU instruction path. It holds the current fetch address, drives it into the `incrementor` and takes the incremented value back as the next address. It issues in-order fetch requests to instruction memory under a valid/ready handshake and tracks up to `MAX_OUT` outstanding requests in a tag FIFO. It tags each returned word with its fetch address and discards responses made stale by a redirect.

## Interface
- `DATA_W`, 32, width of an instruction word.
- `MAX_OUT`, 4, maximum outstanding fetches; power of two, ≥2; sets the tag-FIFO depth.
- `RESET_ADDR`, 32'h0000_0000, reset value of the fetch address.
- Clocking: one clock; reset is asynchronous and active-low.

Ports:
- `clk_main_a0`  in  1  clock; all logic on the rising edge.
- `rst_main_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; IDLE→FETCH, load `start_addr`.
- `start_addr`  in  32  first fetch address.
- `halt`  in  1  pulse; stop issuing, drain outstanding.
- `redirect_valid`  in  1  jump/branch request (FETCH only).
- `redirect_addr`  in  32  jump target.
- `inc_in_address`  out  32  to incrementor `in_address`; equals `pc`.
- `inc_out_address`  in  32  from incrementor `out_address` (`pc`+1, combinational).
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  fetch address; equals `pc`.
- `imem_rsp_valid`  in  1  response valid; in order, no backpressure.
- `imem_rsp_data`  in  DATA_W  fetched word.
- `inst_valid`  out  1  tagged instruction valid (1-cycle pulse per word).
- `inst_addr`  out  32  address of `inst_data`.
- `inst_data`  out  DATA_W  instruction word.
- `outstanding`  out  $clog2(MAX_OUT)+1  in-flight request count.
- `busy`  out  1  state≠IDLE or `outstanding`≠0.
- `err`  out  1  sticky; response arrived with the tag FIFO empty.

## Operation
- Registers: `pc`[31:0], `state`, `epoch` (1 bit), `outstanding`, and a tag FIFO of {epoch, addr}.
- Reset values:
  - `pc`=RESET_ADDR.
  - `state`=IDLE.
  - `epoch`=0.
  - `outstanding`=0.
  - FIFO empty.
  - `inst_valid`=0, `inst_addr`=0, `inst_data`=0.
  - `err`=0.
  - `imem_req_valid`=0.
- States:
  - IDLE: no requests. `start` sets `pc`←`start_addr` and moves to FETCH. `halt` and `redirect_valid` are ignored.
  - FETCH: `imem_req_valid` = (`outstanding`<MAX_OUT) & !`redirect_valid` & !`halt`.
    - On accept (valid&ready): push {`epoch`,`pc`}, then `pc`←`inc_out_address`.
    - `halt` → DRAIN.
    - `redirect_valid` (without `halt`): `pc`←`redirect_addr`, `epoch` toggles. No request is issued that cycle, so a redirect never coincides with an accept.
    - `halt` and `redirect_valid` together: halt wins; the redirect is dropped.
    - `start` is ignored.
  - DRAIN: no requests. When `outstanding` reaches 0 → IDLE; this includes the cycle in which the last response pops. `start` and `redirect_valid` are ignored.
- `imem_req_valid` depends only on registered state and the inputs above, never on `imem_req_ready`.
- Once `imem_req_valid` is high, `imem_req_addr` is stable until accepted. The only exceptions are a redirect or halt, which drop valid that cycle.
- Response handling:
  - `imem_rsp_valid` pops the FIFO head.
  - If head epoch == current `epoch`: next cycle `inst_valid`=1, `inst_addr`=head addr, `inst_data`=`imem_rsp_data`.
  - Otherwise the word is discarded and `inst_valid` stays 0.
  - Response with the FIFO empty: set `err`, no pop, `outstanding` unchanged.
- `outstanding`:
  - +1 on accept.
  - −1 on a valid pop.
  - Accept and pop in the same cycle: unchanged.
  - Never exceeds MAX_OUT.
- Address arithmetic is modulo 2^32: `pc`=32'hFFFF_FFFF advances to 32'h0000_0000 with no flag.
- Asserting `rst_main_n` mid-operation clears everything immediately. Responses arriving after reset deassertion for pre-reset requests set `err`.

## Timing
- `start` at cycle N → `imem_req_valid`=1 with `imem_req_addr`=`start_addr` at N+1.
- With `imem_req_ready` held high, one request issues per cycle at consecutive addresses, up to MAX_OUT in flight.
- `redirect_valid` at N → no request at N; request at `redirect_addr` at N+1 if below the limit.
- `imem_rsp_valid` at N → `inst_valid` at N+1. Zero-bubble throughput.
- Incrementor loop: `pc` register → `inc_in_address` → `inc_out_address` → `pc` D-input, within one cycle.
- `halt` at N → `imem_req_valid`=0 from N. IDLE reached the cycle after `outstanding` hits 0.

## Test plan
- Reset, then `start`/`start_addr`=0x100, ready=1, memory latency 2 → requests 0x100,0x101,0x102…; `inst_addr` 0x100,0x101… in order with the matching data; `outstanding` never >2.
- `imem_req_ready`=0 for 5 cycles with valid high → `imem_req_addr` holds 0x100; issue resumes when ready rises. MAX_OUT=4 with no responses → exactly 4 accepts, then valid=0.
- Redirect to 0x400 with 3 requests outstanding → those 3 responses are dropped (`inst_valid`=0); the next `inst_addr` is 0x400.
- `start_addr`=0xFFFF_FFFE → requests 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- `halt` with 2 outstanding → no new requests; both words delivered; `busy` falls and state is IDLE the cycle after the last response. `halt`+`redirect_valid` together → halt taken, `pc` unchanged.
- `imem_rsp_valid` in IDLE with the FIFO empty → `err`=1 sticky, `inst_valid`=0. Reset mid-FETCH → all outputs return to their reset values immediately.
